// File: rtl/instr_fetch_pkg.sv
// Shared core constants for the fetch front end: instruction size, alignment,
// reset vector and ROM geometry.
package instr_fetch_pkg;

    localparam int unsigned DEF_ADDR_SIZE   = 10;
    localparam int unsigned DEF_WORD_SIZE   = 32;
    localparam int unsigned ILEN_BYTES      = DEF_WORD_SIZE / 8;
    localparam int unsigned ILEN_LOG2       = $clog2(ILEN_BYTES);
    localparam int unsigned DEF_RESET_PC    = 0;
    localparam int unsigned ROM_DEPTH_WORDS = (1 << DEF_ADDR_SIZE) / ILEN_BYTES;

    // Canonical NOP (addi x0, x0, 0), reserved for bubble insertion.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ACT_REDIRECT,
        ACT_STALL,
        ACT_ADVANCE
    } fetch_action_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch initiator for a 1-cycle-latency instruction ROM: drives the fetch
// address, pairs each returned word with its PC and hands it to decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned RESET_PC  = DEF_RESET_PC,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_instr,
    input  logic                 redirect_valid,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_instr,
    output logic [ADDR_SIZE-1:0] out_pc,
    output logic                 misaligned_redirect,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam int unsigned          ILEN       = WORD_SIZE / 8;
    localparam logic [ADDR_SIZE-1:0] PC_STEP    = ADDR_SIZE'(ILEN);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'(ILEN - 1);
    localparam logic [ADDR_SIZE-1:0] RESET_ADDR = ADDR_SIZE'(RESET_PC);

    logic [ADDR_SIZE-1:0] fetch_pc_q,    fetch_pc_d;
    logic [ADDR_SIZE-1:0] inflight_pc_q, inflight_pc_d;
    logic                 inflight_valid_q, inflight_valid_d;
    logic                 misaligned_q,  misaligned_d;
    logic [CNT_WIDTH-1:0] count_q,       count_d;

    logic [ADDR_SIZE-1:0] aligned_pc;
    logic                 stall;
    logic                 accept;
    fetch_action_e        action;

    assign aligned_pc = redirect_pc & ~ALIGN_MASK;
    assign stall      = inflight_valid_q & ~out_ready & ~redirect_valid;
    assign out_valid  = inflight_valid_q & ~redirect_valid;
    assign accept     = out_valid & out_ready;
    assign out_pc     = inflight_pc_q;
    assign out_instr  = out_valid ? imem_instr : '0;

    assign misaligned_redirect = misaligned_q;
    assign fetch_count         = count_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        action           = ACT_ADVANCE;
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        misaligned_d     = 1'b0;
        count_d          = count_q;
        imem_addr        = fetch_pc_q;

        if (redirect_valid) begin
            action = ACT_REDIRECT;
        end else if (stall) begin
            action = ACT_STALL;
        end

        case (action)
            ACT_REDIRECT: begin
                imem_addr        = aligned_pc;
                inflight_pc_d    = aligned_pc;
                inflight_valid_d = 1'b1;
                fetch_pc_d       = aligned_pc + PC_STEP;
                misaligned_d     = |(redirect_pc & ALIGN_MASK);
            end
            // The ROM re-reads the held word so imem_instr stays stable.
            ACT_STALL: begin
                imem_addr = inflight_pc_q;
            end
            default: begin
                imem_addr        = fetch_pc_q;
                inflight_pc_d    = fetch_pc_q;
                inflight_valid_d = 1'b1;
                fetch_pc_d       = fetch_pc_q + PC_STEP;
            end
        endcase

        if (accept) begin
            count_d = count_q + CNT_WIDTH'(1);
        end

        if (!rst_n) begin
            imem_addr = RESET_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q       <= RESET_ADDR;
            inflight_pc_q    <= '0;
            inflight_valid_q <= 1'b0;
            misaligned_q     <= 1'b0;
            count_q          <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            misaligned_q     <= misaligned_d;
            count_q          <= count_d;
        end
    end

endmodule
